// File: rtl/abus_xbar_arb_pkg.sv
// rtl/abus_xbar_arb_pkg.sv - shared constants, FSM type and width helper for the abus crossbar
// Contents: slave select constants, ZERO / WE_DISABLE drive constants, arbiter state enum,
//           clog2() used to size the owner index and hold counter.
package abus_pkg;

  localparam int SLV_RE = 0;
  localparam int SLV_IM = 1;
  localparam int SLV_WN = 2;

  localparam logic ZERO       = 1'b0;
  localparam logic WE_DISABLE = 1'b0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } arb_state_t;

  // Never returns less than 1 so that every index/counter keeps at least one bit.
  function automatic int clog2(input int value);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/abus_xbar_arb_if.sv
// rtl/abus_xbar_arb_if.sv - master/slave bus bundle for the abus crossbar arbiter
// Signals: m_req_i/m_we_i/m_addr_i/m_data_i   master requests (packed, master k at slot k)
//          m_gnt_o/m_rvalid_o/m_err_o/m_data_o grant and read return to the masters
//          s_en_o/s_we_o/s_addr_o/s_data_o     access towards the RAM banks
//          s_data_i                            RAM read data, one cycle after s_en_o
interface abus_xbar_arb_if #(
  parameter int NM = 2,
  parameter int NS = 3,
  parameter int AW = 32,
  parameter int DW = 32
);
  logic [NM-1:0]    m_req_i;
  logic [NM-1:0]    m_we_i;
  logic [NM*AW-1:0] m_addr_i;
  logic [NM*DW-1:0] m_data_i;
  logic [NM-1:0]    m_gnt_o;
  logic [NM-1:0]    m_rvalid_o;
  logic [NM-1:0]    m_err_o;
  logic [DW-1:0]    m_data_o;
  logic [NS-1:0]    s_en_o;
  logic [NS-1:0]    s_we_o;
  logic [NS*AW-1:0] s_addr_o;
  logic [NS*DW-1:0] s_data_o;
  logic [NS*DW-1:0] s_data_i;

  // Arbiter view: serves the masters and drives the RAM banks.
  modport slave (
    input  m_req_i, m_we_i, m_addr_i, m_data_i, s_data_i,
    output m_gnt_o, m_rvalid_o, m_err_o, m_data_o,
    output s_en_o, s_we_o, s_addr_o, s_data_o
  );

  // Environment view: the masters plus the RAM banks.
  modport master (
    output m_req_i, m_we_i, m_addr_i, m_data_i, s_data_i,
    input  m_gnt_o, m_rvalid_o, m_err_o, m_data_o,
    input  s_en_o, s_we_o, s_addr_o, s_data_o
  );
endinterface

// File: rtl/abus_xbar_arb_rr_arb.sv
// rtl/abus_xbar_arb_rr_arb.sv - combinational one-hot winner select (fixed priority or round-robin)
// Ports: i_req     request vector of the candidates
//        i_last    index of the most recent owner (round-robin search starts after it)
//        i_rr_mode 0 = highest index wins, 1 = round-robin
//        o_gnt     one-hot winner, all zero when nobody requests
module abus_rr_arb #(
  parameter int NM = 2,
  parameter int OW = 1
) (
  input  logic [NM-1:0] i_req,
  input  logic [OW-1:0] i_last,
  input  logic          i_rr_mode,
  output logic [NM-1:0] o_gnt
);

  int   w_best;
  logic w_found;

  // Distance of candidate j from the round-robin start point (i_last+1 is 0).
  function automatic int rr_dist(input int j, input logic [OW-1:0] last);
    return (j + 2 * NM - 1 - int'(last)) % NM;
  endfunction

  always_comb begin
    o_gnt   = '0;
    w_best  = NM;
    w_found = 1'b0;
    if (i_rr_mode) begin
      for (int j = 0; j < NM; j++) begin
        if (i_req[j] && (rr_dist(j, i_last) < w_best)) w_best = rr_dist(j, i_last);
      end
      for (int j = 0; j < NM; j++) begin
        o_gnt[j] = i_req[j] && (rr_dist(j, i_last) == w_best);
      end
    end else begin
      for (int j = NM - 1; j >= 0; j--) begin
        o_gnt[j] = i_req[j] && !w_found;
        w_found  = w_found | i_req[j];
      end
    end
  end

endmodule

// File: rtl/abus_xbar_arb.sv
// rtl/abus_xbar_arb.sv - NM-master to NS-slave shared RAM bus arbiter with registered grant
// Ports: clk, rst (async, active high)
//        bus  abus_xbar_arb_if.slave: master requests in, one-hot grant / read return out,
//             RAM bank enable/we/addr/data out, RAM read data in.
module abus_xbar_arb
  import abus_pkg::*;
#(
  parameter int NM       = 2,
  parameter int NS       = 3,
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int SELW     = 4,
  parameter int RR_MODE  = 0,
  parameter int HOLD_MAX = 16
) (
  input  logic           clk,
  input  logic           rst,
  abus_xbar_arb_if.slave bus
);

  localparam int              OW       = clog2(NM);
  localparam int              HW       = clog2(HOLD_MAX + 1);
  localparam logic [HW-1:0]   HOLD_CAP = HW'(HOLD_MAX);
  localparam logic            RR_SEL   = (RR_MODE != 0);

  arb_state_t      r_state;
  logic [NM-1:0]   r_gnt;
  logic [OW-1:0]   r_last;
  logic [HW-1:0]   r_hold;
  logic [NM-1:0]   r_rvalid;
  logic [NM-1:0]   r_err;
  logic [SELW-1:0] r_rsel;

  logic            w_own_req;
  logic            w_own_we;
  logic [AW-1:0]   w_own_addr;
  logic [DW-1:0]   w_own_data;
  logic [SELW-1:0] w_sel;
  logic [AW-1:0]   w_slv_addr;
  logic            w_active;
  logic            w_dec_ok;
  logic [NM-1:0]   w_arb_req;
  logic            w_others;
  logic            w_cap_hit;
  logic            w_release;
  logic [NM-1:0]   w_win;
  logic [OW-1:0]   w_win_idx;

  // Route the current owner's inputs; with no grant everything reads as idle.
  always_comb begin
    w_own_req  = 1'b0;
    w_own_we   = WE_DISABLE;
    w_own_addr = '0;
    w_own_data = '0;
    for (int k = 0; k < NM; k++) begin
      if (r_gnt[k]) begin
        w_own_req  = bus.m_req_i[k];
        w_own_we   = bus.m_we_i[k];
        w_own_addr = bus.m_addr_i[k*AW +: AW];
        w_own_data = bus.m_data_i[k*DW +: DW];
      end
    end
  end

  assign w_sel      = w_own_addr[AW-1 -: SELW];
  assign w_slv_addr = {{SELW{ZERO}}, w_own_addr[AW-SELW-1:0]};
  assign w_active   = w_own_req;
  assign w_dec_ok   = int'(w_sel) < NS;

  // The owner never competes against itself: on release the grant goes to someone else.
  assign w_arb_req  = bus.m_req_i & ~r_gnt;
  assign w_others   = |w_arb_req;
  assign w_cap_hit  = (HOLD_MAX != 0) && (r_hold >= HOLD_CAP);
  assign w_release  = !w_own_req || (w_cap_hit && w_others);

  abus_rr_arb #(
    .NM (NM),
    .OW (OW)
  ) u_arb (
    .i_req     (w_arb_req),
    .i_last    (r_last),
    .i_rr_mode (RR_SEL),
    .o_gnt     (w_win)
  );

  always_comb begin
    w_win_idx = r_last;
    for (int k = 0; k < NM; k++) begin
      if (w_win[k]) w_win_idx = OW'(k);
    end
  end

  // Arbiter FSM plus the one-deep read-return pipeline.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_gnt    <= '0;
      r_last   <= OW'(NM - 1);
      r_hold   <= '0;
      r_rvalid <= '0;
      r_err    <= '0;
      r_rsel   <= '0;
    end else begin
      // Captured from the issuing owner so a read on its last cycle still returns.
      r_rvalid <= (w_active && !w_own_we) ? r_gnt : '0;
      r_err    <= (w_active && !w_dec_ok) ? r_gnt : '0;
      r_rsel   <= w_sel;

      case (r_state)
        ST_IDLE: begin
          if (w_others) begin
            r_gnt   <= w_win;
            r_last  <= w_win_idx;
            r_hold  <= HW'(1);
            r_state <= ST_OWN;
          end
        end
        ST_OWN: begin
          if (w_release) begin
            if (w_others) begin
              r_gnt  <= w_win;
              r_last <= w_win_idx;
              r_hold <= HW'(1);
            end else begin
              r_gnt   <= '0;
              r_hold  <= '0;
              r_state <= ST_IDLE;
            end
          end else if ((HOLD_MAX != 0) && (r_hold != HOLD_CAP)) begin
            r_hold <= r_hold + 1'b1;
          end
        end
      endcase
    end
  end

  assign bus.m_gnt_o    = r_gnt;
  assign bus.m_rvalid_o = r_rvalid;
  assign bus.m_err_o    = r_err;

  // RAM data is only valid the cycle after the access, so the return mux is steered
  // by the registered select rather than registering the data itself.
  always_comb begin
    bus.m_data_o = '0;
    if ((|r_rvalid) && !(|r_err)) begin
      for (int s = 0; s < NS; s++) begin
        if (r_rsel == SELW'(s)) bus.m_data_o = bus.s_data_i[s*DW +: DW];
      end
    end
  end

  always_comb begin
    bus.s_en_o   = '0;
    bus.s_we_o   = {NS{WE_DISABLE}};
    bus.s_addr_o = '0;
    bus.s_data_o = '0;
    for (int s = 0; s < NS; s++) begin
      if (w_active && (int'(w_sel) == s)) begin
        bus.s_en_o[s]           = 1'b1;
        bus.s_we_o[s]           = w_own_we;
        bus.s_addr_o[s*AW +: AW] = w_slv_addr;
        bus.s_data_o[s*DW +: DW] = w_own_data;
      end
    end
  end

endmodule

// File: doc/abus_xbar_arb.md
Name: abus_xbar_arb

Overview:
- Parametrised successor of the sample/FFT shared-RAM bus.
- Arbitrates NM masters (sampler, FFT engine, DMA/readout, ...) onto NS single-port synchronous RAM slaves (real, imag, twiddle, ...).
- Uses a registered grant, selectable fixed-priority or round-robin arbitration, burst lock with starvation cap, and registered read-data return with a per-master valid and decode-error flag.
- Sits between the FFT datapath masters and the RAM banks.

Parameters:
- NM, 2, number of masters (2..8)
- NS, 3, number of slaves (1..16)
- AW, 32, address width
- DW, 32, data width
- SELW, 4, address MSBs used as slave select (addr[AW-1:AW-SELW])
- RR_MODE, 0, 0 = fixed priority (highest index wins), 1 = round-robin
- HOLD_MAX, 16, maximum consecutive granted cycles while another master is requesting (0 = unlimited)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- m_req_i  in  NM  per-master request (level, held for the burst)
- m_we_i  in  NM  per-master write enable
- m_addr_i  in  NM*AW  packed master addresses (master k at [k*AW +: AW])
- m_data_i  in  NM*DW  packed write data
- m_gnt_o  out  NM  one-hot registered grant
- m_rvalid_o  out  NM  read data valid, one cycle after a granted read
- m_err_o  out  NM  decode error, same timing as m_rvalid_o
- m_data_o  out  DW  read data, shared, qualified by m_rvalid_o
- s_en_o  out  NS  slave access enable
- s_we_o  out  NS  slave write enable
- s_addr_o  out  NS*AW  slave address, select bits zeroed ({SELW'0, addr[AW-SELW-1:0]})
- s_data_o  out  NS*DW  slave write data
- s_data_i  in  NS*DW  slave read data, valid one cycle after s_en_o

Behaviour:
- Reset values: m_gnt_o=0, m_rvalid_o=0, m_err_o=0, m_data_o=0, hold counter=0. Round-robin pointer last=NM-1, so master 0 wins first.
- All s_* outputs are combinational from the grant register and the owner's inputs, so they are 0 in reset.
- Arbiter FSM has two states:
  - IDLE: no grant. If any m_req_i is set, the winner is latched into m_gnt_o at the next edge and the FSM goes to OWN.
  - OWN: the owner keeps the grant while its req stays high. It releases when its req drops, or when the hold counter reaches HOLD_MAX and another req is pending. On release, arbitration among the remaining requesters happens at the same edge (no bubble). If none remain, the FSM returns to IDLE.
- Winner selection:
  - Fixed priority: highest index wins.
  - Round-robin: the search starts at last+1 and wraps modulo NM. last updates to the new owner on every grant.
- The hold counter increments each OWN cycle and clears on grant change. It saturates at HOLD_MAX and is ignored when HOLD_MAX=0.
- A master whose req rises in the same cycle another master is granted waits. The grant never changes mid-cycle.
- Access issue: in a cycle with m_gnt_o[k] & m_req_i[k], sel = m_addr_i[k] top SELW bits.
  - If sel < NS: s_en_o[sel]=1 and s_we_o[sel]=m_we_i[k]; address and data are routed to that slave. All other slaves see 0.
  - If sel >= NS: no slave is enabled.
- Read return: for a read issued at cycle t, the registered owner index, sel and error are captured. At cycle t+1:
  - m_rvalid_o[k]=1 and m_data_o = s_data_i[sel].
  - On decode error: m_err_o[k]=1 and m_data_o=0.
- Writes produce no rvalid; a decode-error write still pulses m_err_o[k] at t+1.
- Back-to-back reads give one result per cycle, fully pipelined.
- A read issued on the owner's last granted cycle still returns at t+1 even though the grant has moved.
- Grant to a master that drops req in the same cycle: no access is issued. The release takes effect at that edge.
- Reset asserted mid-burst: all outputs clear asynchronously. A pending read return is discarded.

Decomposition:
- Package abus_pkg holds: slave select constants (SLV_RE=0, SLV_IM=1, SLV_WN=2), the ZERO and WE_DISABLE constants, and a function clog2 for the owner index width.
- One sub-module, abus_rr_arb: request vector, last pointer and mode in; one-hot winner out (combinational). It is instantiated once.

Test Plan:
- Reset, then m_req_i=01 with a read at addr 0x1000_0004 → m_gnt_o=01 at next edge. s_en_o[1]=1 with s_addr_o=0x0000_0004. One cycle later m_rvalid_o[0]=1 and m_data_o equals the RAM1 word.
- RR_MODE=1, NM=2, both requesting continuously with HOLD_MAX=4 → grant alternates 01 for 4 cycles, then 10 for 4 cycles, with no idle cycle between.
- RR_MODE=0, both requesting → master 1 holds the grant until its req drops. At that same edge master 0 is granted.
- Master 0 writes 0xDEAD_BEEF to 0x2000_0010, then reads it back → s_we_o[2]=1 only on the write cycle. The read returns 0xDEAD_BEEF with m_err_o=0.
- Read at 0x7000_0000 with NS=3 → s_en_o=0 and m_rvalid_o[k]=1 with m_err_o[k]=1 and m_data_o=0 at t+1.
- Assert rst during a 4-read burst → m_gnt_o, m_rvalid_o and s_en_o go to 0 immediately. After release, master 0 is granted first.
